i2c_init_seq: RTL and testbench

Sequencer that owns the request/response port of the I2C master. After reset it replays a register-initialisation table from an external ROM as I2C writes, with per-entry retry on NACK. It then hands the master to one runtime client through a registered passthrough. It sits between the I2C master and the board-control logic (codec/PMIC setup at boot, then runtime register access).

---
 rtl/i2c_init_seq.sv | 184 ++++++++++++++++++
 tb/tb_i2c_init_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_init_seq.sv
// Boot-time I2C register initialiser: replays a ROM table as I2C writes with
// per-entry retry on NACK, then hands the master port to one runtime client.
`timescale 1ns/1ps
module i2c_init_seq #(
  parameter int N_INIT  = 16,
  parameter int RETRIES = 3,
  parameter int GAP     = 120,
  localparam int IW     = $clog2(N_INIT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  output logic [IW-1:0] rom_addr_o,
  input  logic [22:0]   rom_data_i,
  output logic          m_val_o,
  output logic [6:0]    m_daddr_o,
  output logic [7:0]    m_addr_o,
  output logic [7:0]    m_data_o,
  output logic          m_wen_o,
  input  logic          m_rdy_i,
  input  logic          r_val_i,
  input  logic          r_err_i,
  input  logic [7:0]    r_data_i,
  output logic          r_rdy_o,
  input  logic          c_val_i,
  input  logic [6:0]    c_daddr_i,
  input  logic [7:0]    c_addr_i,
  input  logic [7:0]    c_data_i,
  input  logic          c_wen_i,
  output logic          c_rdy_o,
  output logic          c_rval_o,
  output logic          c_rerr_o,
  output logic [7:0]    c_rdata_o,
  input  logic          c_rrdy_i,
  output logic          init_done_o,
  output logic          init_fail_o,
  output logic [IW-1:0] fail_idx_o
);

  localparam int RW = $clog2(RETRIES + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [3:0] {
    S_FETCH, S_LOAD, S_ISSUE, S_WAIT, S_GAP,
    S_C_IDLE, S_C_ISSUE, S_C_WAIT, S_C_RESP
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [RW-1:0] retry_cnt;
  logic [GW-1:0] gap_cnt;
  logic          again;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= S_FETCH;
      idx         <= '0;
      retry_cnt   <= '0;
      gap_cnt     <= '0;
      again       <= 1'b0;
      rom_addr_o  <= '0;
      m_val_o     <= 1'b0;
      m_daddr_o   <= '0;
      m_addr_o    <= '0;
      m_data_o    <= '0;
      m_wen_o     <= 1'b0;
      r_rdy_o     <= 1'b0;
      c_rdy_o     <= 1'b0;
      c_rval_o    <= 1'b0;
      c_rerr_o    <= 1'b0;
      c_rdata_o   <= '0;
      init_done_o <= 1'b0;
      init_fail_o <= 1'b0;
      fail_idx_o  <= '0;
    end else begin
      unique case (state)
        S_FETCH: state <= S_LOAD;

        S_LOAD: begin
          m_daddr_o <= rom_data_i[22:16];
          m_addr_o  <= rom_data_i[15:8];
          m_data_o  <= rom_data_i[7:0];
          m_wen_o   <= 1'b1;
          // Zero device address marks a short table; idx limit covers a full one.
          if (idx == IW'(N_INIT) || rom_data_i[22:16] == 7'd0) begin
            init_done_o <= 1'b1;
            c_rdy_o     <= 1'b1;
            state       <= S_C_IDLE;
          end else begin
            m_val_o <= 1'b1;
            state   <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (m_rdy_i) begin
            m_val_o <= 1'b0;
            r_rdy_o <= 1'b1;
            state   <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (r_val_i) begin
            r_rdy_o <= 1'b0;
            if (!r_err_i) begin
              retry_cnt <= '0;
              idx       <= idx + IW'(1);
              again     <= 1'b0;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else if (int'(retry_cnt) + 1 < RETRIES) begin
              retry_cnt <= retry_cnt + RW'(1);
              again     <= 1'b1;
              gap_cnt   <= '0;
              state     <= S_GAP;
            end else begin
              init_fail_o <= 1'b1;
              fail_idx_o  <= idx;
              init_done_o <= 1'b1;
              c_rdy_o     <= 1'b1;
              state       <= S_C_IDLE;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == GW'(GAP - 1)) begin
            if (again) begin
              m_val_o <= 1'b1;
              state   <= S_ISSUE;
            end else begin
              rom_addr_o <= idx;
              state      <= S_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end

        // Runtime passthrough: one outstanding client transaction at a time.
        S_C_IDLE: begin
          if (c_val_i) begin
            m_daddr_o <= c_daddr_i;
            m_addr_o  <= c_addr_i;
            m_data_o  <= c_data_i;
            m_wen_o   <= c_wen_i;
            c_rdy_o   <= 1'b0;
            m_val_o   <= 1'b1;
            state     <= S_C_ISSUE;
          end
        end

        S_C_ISSUE: begin
          if (m_rdy_i) begin
            m_val_o <= 1'b0;
            r_rdy_o <= 1'b1;
            state   <= S_C_WAIT;
          end
        end

        S_C_WAIT: begin
          if (r_val_i) begin
            r_rdy_o   <= 1'b0;
            c_rerr_o  <= r_err_i;
            c_rdata_o <= r_data_i;
            c_rval_o  <= 1'b1;
            state     <= S_C_RESP;
          end
        end

        S_C_RESP: begin
          if (c_rrdy_i) begin
            c_rval_o <= 1'b0;
            c_rdy_o  <= 1'b1;
            state    <= S_C_IDLE;
          end
        end

        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_init_seq.sv
// Directed bench for i2c_init_seq: ROM model, responding I2C master model and
// a request scoreboard fed by the directed steps.
`timescale 1ns/1ps
module tb_i2c_init_seq;
  localparam int N_INIT  = 16;
  localparam int RETRIES = 3;
  localparam int GAP     = 20;
  localparam int IW      = $clog2(N_INIT + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [IW-1:0] rom_addr;
  logic [22:0]   rom_data;
  logic          m_val, m_wen, m_rdy;
  logic [6:0]    m_daddr;
  logic [7:0]    m_addr, m_data;
  logic          r_val, r_err, r_rdy;
  logic [7:0]    r_data;
  logic          c_val, c_wen, c_rdy, c_rval, c_rerr, c_rrdy;
  logic [6:0]    c_daddr;
  logic [7:0]    c_addr, c_data, c_rdata;
  logic          init_done, init_fail;
  logic [IW-1:0] fail_idx;

  i2c_init_seq #(.N_INIT(N_INIT), .RETRIES(RETRIES), .GAP(GAP)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rom_addr_o(rom_addr), .rom_data_i(rom_data),
    .m_val_o(m_val), .m_daddr_o(m_daddr), .m_addr_o(m_addr), .m_data_o(m_data),
    .m_wen_o(m_wen), .m_rdy_i(m_rdy),
    .r_val_i(r_val), .r_err_i(r_err), .r_data_i(r_data), .r_rdy_o(r_rdy),
    .c_val_i(c_val), .c_daddr_i(c_daddr), .c_addr_i(c_addr), .c_data_i(c_data),
    .c_wen_i(c_wen), .c_rdy_o(c_rdy),
    .c_rval_o(c_rval), .c_rerr_o(c_rerr), .c_rdata_o(c_rdata), .c_rrdy_i(c_rrdy),
    .init_done_o(init_done), .init_fail_o(init_fail), .fail_idx_o(fail_idx)
  );

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int max_rom = 0;
  bit early_rdy;
  logic [7:0]  rd_data;
  logic [22:0] rom [0:N_INIT];
  logic [23:0] exp_q [$];
  logic        err_q [$];

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= (int'(rom_addr) <= N_INIT) ? rom[rom_addr] : '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [22:0] ent(input int i, input logic [7:0] base);
    return {7'h1A, 8'(i), 8'(base + 8'(i) * 8'h22)};
  endfunction

  task automatic set_rom(input int n, input logic [7:0] base);
    for (int i = 0; i <= N_INIT; i++) rom[i] = (i < n) ? ent(i, base) : '0;
  endtask

  task automatic push_exp(input int i, input logic [7:0] base);
    exp_q.push_back({ent(i, base), 1'b1});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    err_q.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!init_done && n < limit) begin
      if (c_rdy) early_rdy = 1'b1;
      @(negedge clk);
      n++;
    end
    chk("init_done", init_done, 1);
  endtask

  // Master model: accepts every request, answers two cycles later, scores payload/spacing.
  initial begin : master_model
    logic [23:0] got, prev;
    int cnt, last_req;
    bit pend, rxfer;
    pend = 0; rxfer = 0; cnt = 0; last_req = -1; prev = '0;
    r_val = 0; r_err = 0; r_data = 0; m_rdy = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        r_val = 0; r_err = 0; pend = 0; rxfer = 0; last_req = -1;
      end else begin
        if (rxfer) begin r_val = 0; rxfer = 0; end
        if (pend) begin
          if (cnt == 0) begin
            r_val  = 1'b1;
            r_err  = (err_q.size() != 0) ? err_q.pop_front() : 1'b0;
            r_data = rd_data;
            pend   = 0;
          end else cnt--;
        end
        if (r_val && r_rdy) rxfer = 1;
        if (m_val && m_rdy) begin
          got = {m_daddr, m_addr, m_data, m_wen};
          vectors++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_req: observed %h expected none", got);
          end
          if (exp_q.size() != 0) chk("req_payload", 32'(got), 32'(exp_q.pop_front()));
          if (!init_done && last_req >= 0)
            chk("req_spacing", 32'(cyc - last_req), 32'((got == prev) ? GAP + 3 : GAP + 5));
          if (!init_done) last_req = cyc;
          prev = got;
          pend = 1; cnt = 1;
        end
        if (int'(rom_addr) > max_rom) max_rom = int'(rom_addr);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0; c_val = 0; c_daddr = 0; c_addr = 0; c_data = 0; c_wen = 0; c_rrdy = 0;
    rd_data = 8'h00; early_rdy = 0;
    set_rom(3, 8'h12);
    repeat (3) @(negedge clk);
    chk("rst_m_val", m_val, 0);
    chk("rst_r_rdy", r_rdy, 0);
    chk("rst_c_rdy", c_rdy, 0);
    chk("rst_c_rval", c_rval, 0);
    chk("rst_flags", {init_done, init_fail, fail_idx}, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_req", {m_daddr, m_addr, m_data, m_wen}, 0);

    // 3-entry table, all ACKed, client read held pending through init
    for (int i = 0; i < 3; i++) push_exp(i, 8'h12);
    c_val = 1; c_daddr = 7'h50; c_addr = 8'h10; c_data = 8'h00; c_wen = 0;
    exp_q.push_back({7'h50, 8'h10, 8'h00, 1'b0});
    rd_data = 8'hA5;
    rst_n = 1;
    @(negedge clk); chk("cyc1_m_val", m_val, 0);
    @(negedge clk); chk("cyc2_m_val", m_val, 1);
    wait_done(2000);
    chk("t1_fail", init_fail, 0);
    chk("t1_no_early_c_rdy", early_rdy, 0);
    chk("t1_c_rdy", c_rdy, 1);
    @(negedge clk); c_val = 0;
    n = 0;
    while (!c_rval && n < 50) begin @(negedge clk); n++; end
    for (int k = 0; k < 5; k++) begin
      chk("c_rval_held", c_rval, 1);
      chk("c_rdata", c_rdata, 8'hA5);
      chk("c_rerr", c_rerr, 0);
      @(negedge clk);
    end
    c_rrdy = 1;
    @(negedge clk);
    c_rrdy = 0;
    chk("c_rval_drop", c_rval, 0);
    chk("c_rdy_back", c_rdy, 1);
    chk("t1_all_issued", exp_q.size(), 0);

    // entry 1 NACKed once then ACKed
    do_reset();
    set_rom(3, 8'h12);
    push_exp(0, 8'h12); push_exp(1, 8'h12); push_exp(1, 8'h12); push_exp(2, 8'h12);
    err_q.push_back(0); err_q.push_back(1); err_q.push_back(0); err_q.push_back(0);
    rst_n = 1;
    wait_done(2000);
    chk("t2_fail", init_fail, 0);
    chk("t2_all_issued", exp_q.size(), 0);

    // entry 2 NACKed RETRIES times
    do_reset();
    set_rom(4, 8'h40);
    push_exp(0, 8'h40); push_exp(1, 8'h40);
    for (int k = 0; k < RETRIES; k++) push_exp(2, 8'h40);
    err_q.push_back(0); err_q.push_back(0);
    for (int k = 0; k < RETRIES; k++) err_q.push_back(1);
    rst_n = 1;
    wait_done(2000);
    chk("t3_fail", init_fail, 1);
    chk("t3_fail_idx", fail_idx, 2);
    chk("t3_c_rdy", c_rdy, 1);
    repeat (60) @(negedge clk);
    chk("t3_all_issued", exp_q.size(), 0);
    chk("t3_done_sticky", {init_done, init_fail, fail_idx}, {1'b1, 1'b1, IW'(2)});

    // full table, non-zero word beyond the last index
    do_reset();
    set_rom(N_INIT + 1, 8'h07);
    for (int i = 0; i < N_INIT; i++) push_exp(i, 8'h07);
    max_rom = 0;
    rst_n = 1;
    wait_done(4000);
    repeat (30) @(negedge clk);
    chk("t4_fail", init_fail, 0);
    chk("t4_all_issued", exp_q.size(), 0);
    chk("t4_rom_addr_max", max_rom, N_INIT);
    chk("t4_rom_addr_end", rom_addr, N_INIT);

    // reset while waiting for entry 1 response
    do_reset();
    set_rom(3, 8'h12);
    for (int i = 0; i < 3; i++) push_exp(i, 8'h12);
    rst_n = 1;
    n = 0;
    while (!(r_rdy && m_addr == 8'h01) && n < 500) begin @(negedge clk); n++; end
    chk("t5_reached_wait1", {r_rdy, m_addr}, {1'b1, 8'h01});
    rst_n = 0;
    @(negedge clk);
    chk("t5_rst_ctrl", {m_val, r_rdy, c_rdy, c_rval}, 0);
    chk("t5_rst_flags", {init_done, init_fail, fail_idx}, 0);
    chk("t5_rst_req", {rom_addr, m_daddr, m_addr, m_data, m_wen}, 0);
    exp_q.delete();
    err_q.delete();
    for (int i = 0; i < 3; i++) push_exp(i, 8'h12);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk); chk("t5_cyc1_m_val", m_val, 0);
    @(negedge clk); chk("t5_restart_idx0", {m_val, m_addr}, {1'b1, 8'h00});
    wait_done(2000);
    chk("t5_fail", init_fail, 0);
    chk("t5_all_issued", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
